// File: rtl/sram_pkg.sv
// Shared constants and state type for the SRAM chip model.
package sram_pkg;
    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam logic [15:0] WR_COUNT_MAX = 16'hFFFF;

    typedef enum logic {CLEAR, ACTIVE} state_t;
endpackage

// File: rtl/sram_if.sv
// SRAM control/address pins; the controller is the master, the chip model the slave.
interface sram_if;
    import sram_pkg::*;

    logic [SRAM_ADDR_W-1:0] SRAM_ADDR;
    logic                   SRAM_UB_N;
    logic                   SRAM_LB_N;
    logic                   SRAM_WE_N;
    logic                   SRAM_CE_N;
    logic                   SRAM_OE_N;
    // Per-lane DQ drive indication from the chip: [1]=upper, [0]=lower byte.
    logic [1:0]             dq_drive;

    modport master (
        output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N,
        input  dq_drive
    );
    modport slave (
        input  SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N,
        output dq_drive
    );
endinterface

// File: rtl/sram_byte_array.sv
// 2**DEPTH_LOG2 x 16 storage: one byte-enabled synchronous write port, one async read port.
module sram_byte_array #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic [1:0]            be,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [15:0]           wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [15:0]           rd_data
);
    logic [15:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (be[0]) mem[wr_addr][7:0]  <= wr_data[7:0];
        if (be[1]) mem[wr_addr][15:8] <= wr_data[15:8];
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sram_responder.sv
// Device-side model of a 256K x 16 async SRAM: clear-after-reset, byte-lane writes, tri-state reads.
// Define SRAM_REG_READ_EN to delay the read data and drive window by one clock.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W         = SRAM_ADDR_W,
    parameter int DATA_W         = SRAM_DATA_W,
    parameter int DEPTH_LOG2     = 12,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    sram_if.slave             bus,
    output logic              init_done,
    output logic [15:0]       wr_count,
    output logic              addr_err
);
    localparam logic [DEPTH_LOG2-1:0] LAST = {DEPTH_LOG2{1'b1}};

    state_t                state, state_nx;
    logic [DEPTH_LOG2-1:0] clr_ptr, idx, wr_addr, rd_addr;
    logic                  active, wr_cyc, rd_en, oor;
    logic [1:0]            be, lanes, drive;
    logic [15:0]           wr_data, rd_data;

    assign active = (state == ACTIVE);
    assign idx    = bus.SRAM_ADDR[DEPTH_LOG2-1:0];
    assign oor    = |bus.SRAM_ADDR[ADDR_W-1:DEPTH_LOG2];
    assign lanes  = {~bus.SRAM_UB_N, ~bus.SRAM_LB_N};
    assign wr_cyc = active & ~bus.SRAM_CE_N & ~bus.SRAM_WE_N;
    assign rd_en  = active & ~bus.SRAM_CE_N & bus.SRAM_WE_N & ~bus.SRAM_OE_N;

    // The clear sequencer shares the single write port with the pins.
    always_comb begin
        state_nx = state;
        be       = 2'b00;
        wr_addr  = idx;
        wr_data  = SRAM_DQ;
        case (state)
            CLEAR: begin
                be      = 2'b11;
                wr_addr = clr_ptr;
                wr_data = '0;
                if (clr_ptr == LAST) state_nx = ACTIVE;
            end
            ACTIVE: if (wr_cyc) be = lanes;
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= (CLEAR_ON_RESET != 0) ? CLEAR : ACTIVE;
            clr_ptr   <= '0;
            init_done <= 1'b0;
            wr_count  <= '0;
            addr_err  <= 1'b0;
        end else begin
            state     <= state_nx;
            init_done <= (state_nx == ACTIVE);
            if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
            if (wr_cyc && wr_count != WR_COUNT_MAX) wr_count <= wr_count + 16'd1;
            if (active && !bus.SRAM_CE_N && (!bus.SRAM_WE_N || !bus.SRAM_OE_N) && oor)
                addr_err <= 1'b1;
        end
    end

`ifdef SRAM_REG_READ_EN
    logic [1:0]            lanes_q;
    logic [DEPTH_LOG2-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lanes_q <= 2'b00;
            idx_q   <= '0;
        end else begin
            lanes_q <= rd_en ? lanes : 2'b00;
            idx_q   <= idx;
        end
    end

    // Async read of idx_q already reflects any write at the preceding edge;
    // the drive is dropped whenever the pins show a write, to avoid bus contention.
    assign rd_addr = idx_q;
    assign drive   = (active && !(!bus.SRAM_CE_N && !bus.SRAM_WE_N)) ? lanes_q : 2'b00;
`else
    assign rd_addr = idx;
    assign drive   = rd_en ? lanes : 2'b00;
`endif

    sram_byte_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk     (clk),
        .be      (be),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign SRAM_DQ[7:0]  = drive[0] ? rd_data[7:0]  : 8'bz;
    assign SRAM_DQ[15:8] = drive[1] ? rd_data[15:8] : 8'bz;
    assign bus.dq_drive  = drive;
endmodule

// File: tb/tb_sram_responder.sv
// Randomised scoreboard bench for sram_responder (DEPTH_LOG2=4) against a behavioural SRAM model.
module tb_sram_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] wr_count;
    logic init_done, addr_err;
    wire  [15:0] dq;
    logic [15:0] tb_dq = 16'h0;
    logic        tb_dq_en = 1'b0;

    sram_if bus();

    assign dq = tb_dq_en ? tb_dq : 16'hzzzz;

    sram_responder #(.DEPTH_LOG2(4), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst(rst), .SRAM_DQ(dq), .bus(bus),
        .init_done(init_done), .wr_count(wr_count), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  drv;
        logic [15:0] data;
        logic [15:0] wrc;
        logic        aerr;
        logic        init;
        string       tag;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_pass = 0;

    // Reference model: memory contents and externally visible status.
    logic [15:0] m_mem [16];
    bit          m_active = 0, m_init = 0, m_aerr = 0;
    int          m_clear_left = 0;
    int          m_wrc = 0;
    logic [1:0]  m_prev_lanes = 2'b00;
    int          m_prev_idx = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [15:0] mask, got;
            e = q.pop_front();
            mask = {{8{e.drv[1]}}, {8{e.drv[0]}}};
            got  = dq & mask;
            n_chk++;
            if (bus.dq_drive === e.drv && got === (e.data & mask) && wr_count === e.wrc
                && addr_err === e.aerr && init_done === e.init)
                n_pass++;
            else
                $display("FAIL %s: got drv=%b dq=%h wr_count=%h addr_err=%b init_done=%b; want drv=%b dq=%h wr_count=%h addr_err=%b init_done=%b",
                         e.tag, bus.dq_drive, got, wr_count, addr_err, init_done,
                         e.drv, e.data & mask, e.wrc, e.aerr, e.init);
        end
    end

    // One bus cycle: apply pins, queue what the chip must show this cycle, then
    // advance the model across the closing clock edge.
    task automatic step(input bit r, input bit ce_n, input bit we_n, input bit oe_n,
                        input bit ub_n, input bit lb_n, input logic [17:0] a,
                        input logic [15:0] d, input string tag);
        exp_t e;
        bit rd, wr;
        int i;
        rst = r;
        bus.SRAM_ADDR = a; bus.SRAM_CE_N = ce_n; bus.SRAM_WE_N = we_n;
        bus.SRAM_OE_N = oe_n; bus.SRAM_UB_N = ub_n; bus.SRAM_LB_N = lb_n;
        tb_dq = d; tb_dq_en = !we_n;
        i  = int'(a % 18'd16);
        rd = m_active && !ce_n && we_n && !oe_n;
        wr = m_active && !ce_n && !we_n;
`ifdef SRAM_REG_READ_EN
        e.drv  = (m_active && !wr) ? m_prev_lanes : 2'b00;
        e.data = m_mem[m_prev_idx];
`else
        e.drv  = rd ? {!ub_n, !lb_n} : 2'b00;
        e.data = m_mem[i];
`endif
        e.wrc = 16'(m_wrc); e.aerr = m_aerr; e.init = m_init; e.tag = tag;
        q.push_back(e);

        if (r) begin
            m_active = 0; m_init = 0; m_aerr = 0; m_wrc = 0;
            m_clear_left = 16; m_prev_lanes = 2'b00; m_prev_idx = 0;
        end else begin
            if (wr) begin
                if (!lb_n) m_mem[i][7:0]  = d[7:0];
                if (!ub_n) m_mem[i][15:8] = d[15:8];
                if (m_wrc < 65535) m_wrc++;
            end
            if (m_active && !ce_n && (!we_n || !oe_n) && a >= 18'd16) m_aerr = 1;
            m_prev_lanes = rd ? {!ub_n, !lb_n} : 2'b00;
            m_prev_idx   = i;
            if (m_clear_left > 0) begin
                m_clear_left--;
                if (m_clear_left == 0) begin
                    foreach (m_mem[k]) m_mem[k] = 16'h0000;
                    m_active = 1;
                end
            end
            m_init = m_active;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) step(0, 1, 1, 1, 1, 1, 18'h0, 16'h0, tag);
    endtask

    task automatic wr(input logic [17:0] a, input logic [15:0] d, input bit ub_n,
                      input bit lb_n, input string tag);
        step(0, 0, 0, 1, ub_n, lb_n, a, d, tag);
    endtask

    task automatic rdc(input logic [17:0] a, input bit ub_n, input bit lb_n, input string tag);
        step(0, 0, 1, 0, ub_n, lb_n, a, 16'h0, tag);
    endtask

    initial begin
        bus.SRAM_ADDR = '0; bus.SRAM_CE_N = 1; bus.SRAM_WE_N = 1;
        bus.SRAM_OE_N = 1; bus.SRAM_UB_N = 1; bus.SRAM_LB_N = 1;
        @(posedge clk); #1;

        for (int k = 0; k < 3; k++) step(1, 1, 1, 1, 1, 1, 18'h0, 16'h0, "reset");
        idle(2, "clear");
        wr(18'h2, 16'h5555, 0, 0, "clear_write_ignored");
        rdc(18'h2, 0, 0, "clear_read_z");
        idle(14, "clear_done");

        for (int k = 0; k < 16; k++) rdc(18'(k), 0, 0, "zero_fill");

        wr(18'h5, 16'hBEEF, 0, 0, "beef_write");
        rdc(18'h5, 0, 0, "beef_read");
        rdc(18'h5, 0, 0, "beef_read2");

        wr(18'h3, 16'h1234, 0, 0, "lane_full");
        wr(18'h3, 16'hAB00, 0, 1, "lane_upper");
        rdc(18'h3, 0, 0, "lane_read");
        rdc(18'h3, 0, 1, "lane_lb_off");
        rdc(18'h3, 1, 0, "lane_ub_off");

        wr(18'h00013, 16'h7777, 0, 0, "alias_write");
        rdc(18'h3, 0, 0, "alias_read");
        idle(2, "aerr_sticky");

        step(0, 1, 1, 0, 0, 0, 18'h5, 16'h0, "ce_off_z");
        step(0, 0, 1, 1, 0, 0, 18'h5, 16'h0, "oe_off_z");
        step(0, 0, 0, 0, 0, 0, 18'h6, 16'hC0DE, "we_over_oe");
        rdc(18'h6, 0, 0, "we_over_oe_read");
        idle(1, "pre_reset");

        step(1, 1, 1, 1, 1, 1, 18'h0, 16'h0, "aerr_reset");
        idle(5, "midclear");
        step(1, 1, 1, 1, 1, 1, 18'h0, 16'h0, "midclear_reset");
        step(1, 1, 1, 1, 1, 1, 18'h0, 16'h0, "midclear_reset");
        idle(17, "reclear");
        rdc(18'h5, 0, 0, "reclear_read");

        for (int k = 0; k < 500; k++) begin
            bit ce_n, we_n, oe_n, ub_n, lb_n;
            logic [17:0] a;
            ce_n = ($urandom_range(0, 7) == 0);
            we_n = ($urandom_range(0, 2) != 0);
            oe_n = ($urandom_range(0, 3) == 0);
            ub_n = ($urandom_range(0, 3) == 0);
            lb_n = ($urandom_range(0, 3) == 0);
            a = 18'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) a[17:4] = 14'($urandom_range(1, 16383));
            step(0, ce_n, we_n, oe_n, ub_n, lb_n, a, 16'($urandom), "random");
        end

        idle(1, "pre_sat");
        step(1, 1, 1, 1, 1, 1, 18'h0, 16'h0, "sat_reset");
        idle(16, "sat_clear");
        for (int k = 0; k < 65540; k++)
            wr(18'($urandom_range(0, 15)), 16'($urandom), bit'($urandom_range(0, 1)),
               bit'($urandom_range(0, 1)), "saturate");
        idle(2, "sat_hold");

        @(negedge clk); #1;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending, want 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
